// File: rtl/shape_draw_sequencer.sv
// shape_draw_sequencer: queues shape draw requests and hands them one at a
// time to the pixel drawer. It loads start_x/start_y/start_colour, pulses
// starting_address_loaded, and then follows the drawer's shape_done level.
// Optional build macro: ERASE_PASS_EN. When it is defined, each request first
// draws an erase shape at the previous position in ERASE_COLOUR.
module shape_draw_sequencer #(
   parameter int X_WIDTH      = 8,
   parameter int Y_WIDTH      = 7,
   parameter int COLOUR_WIDTH = 3,
   parameter int DEPTH        = 4
`ifdef ERASE_PASS_EN
   , parameter logic [COLOUR_WIDTH-1:0] ERASE_COLOUR = '0
`endif
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [X_WIDTH-1:0]      req_x,
   input  logic [Y_WIDTH-1:0]      req_y,
   input  logic [COLOUR_WIDTH-1:0] req_colour,
   input  logic                    shape_done,
   output logic                    starting_address_loaded,
   output logic [X_WIDTH-1:0]      start_x,
   output logic [Y_WIDTH-1:0]      start_y,
   output logic [COLOUR_WIDTH-1:0] start_colour,
   output logic                    busy,
   output logic [15:0]             shapes_drawn
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = X_WIDTH + Y_WIDTH + COLOUR_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE
`ifdef ERASE_PASS_EN
      , ISSUE_ERASE
`endif
   } state_t;

   state_t state, next;

   logic [ENT_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [PTR_W:0]     count;
   logic               empty, full, push, pop, done_exit;
   logic [ENT_W-1:0]   head;

   assign empty     = (count == '0);
   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign req_ready = !full;
   assign push      = req_valid && req_ready;
   assign head      = mem[rd_ptr];
   assign done_exit = (state == WAIT_DONE) && shape_done;
   assign busy      = (state != IDLE);
`ifdef ERASE_PASS_EN
   assign starting_address_loaded = (state == ISSUE) || (state == ISSUE_ERASE);
`else
   assign starting_address_loaded = (state == ISSUE);
`endif

   // FIFO storage; contents are don't-care while the slot is empty
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= {req_x, req_y, req_colour};
   end

   // FIFO pointers and occupancy; push and pop together leave count unchanged
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next;
   end

`ifdef ERASE_PASS_EN
   logic [X_WIDTH-1:0] prev_x;
   logic [Y_WIDTH-1:0] prev_y;
   logic               have_prev, erase_phase;
   logic [ENT_W-1:0]   pend;
`endif

   // Next-state and pop decision; a pop only happens when the drawer is idle
   always_comb begin
      next = state;
      pop  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && shape_done) begin
               pop  = 1'b1;
               next = ISSUE;
`ifdef ERASE_PASS_EN
               if (have_prev) next = ISSUE_ERASE;
`endif
            end
         end
         ISSUE:     next = WAIT_ACK;
`ifdef ERASE_PASS_EN
         ISSUE_ERASE: next = WAIT_ACK;
`endif
         WAIT_ACK:  if (!shape_done) next = WAIT_DONE;
         WAIT_DONE: begin
            if (shape_done) begin
               next = IDLE;
`ifdef ERASE_PASS_EN
               if (erase_phase) next = ISSUE;
`endif
            end
         end
         default:   next = IDLE;
      endcase
   end

   // Shape start registers; they hold steady for the whole shape
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         start_x      <= '0;
         start_y      <= '0;
         start_colour <= '0;
`ifdef ERASE_PASS_EN
         prev_x       <= '0;
         prev_y       <= '0;
         have_prev    <= 1'b0;
         erase_phase  <= 1'b0;
         pend         <= '0;
`endif
      end else begin
`ifdef ERASE_PASS_EN
         if (pop && have_prev) begin
            // erase the last drawn shape first, park the new request
            start_x      <= prev_x;
            start_y      <= prev_y;
            start_colour <= ERASE_COLOUR;
            pend         <= head;
            erase_phase  <= 1'b1;
         end else if (pop) begin
            {start_x, start_y, start_colour} <= head;
            {prev_x, prev_y}                 <= head[ENT_W-1:COLOUR_WIDTH];
            have_prev                        <= 1'b1;
         end else if (done_exit && erase_phase) begin
            {start_x, start_y, start_colour} <= pend;
            {prev_x, prev_y}                 <= pend[ENT_W-1:COLOUR_WIDTH];
            erase_phase                      <= 1'b0;
         end
`else
         if (pop) {start_x, start_y, start_colour} <= head;
`endif
      end
   end

   // Completed-shape counter, wraps naturally at 16 bits
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)        shapes_drawn <= '0;
      else if (done_exit) shapes_drawn <= shapes_drawn + 1'b1;
   end

endmodule

// File: tb/tb_shape_draw_sequencer.sv
// Directed testbench for shape_draw_sequencer with a simple drawer model.
// The drawer model drops shape_done one cycle after each strobe and holds it
// low for draw_len cycles. Every strobe is logged for checking order.
module tb_shape_draw_sequencer;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_x = '0;
   logic [6:0] req_y = '0;
   logic [2:0] req_colour = '0;
   logic       shape_done = 1'b1;
   logic       starting_address_loaded;
   logic [7:0] start_x;
   logic [6:0] start_y;
   logic [2:0] start_colour;
   logic       busy;
   logic [15:0] shapes_drawn;

   int n_assert = 0;
   int n_fail   = 0;

   int draw_len  = 20;
   int draw_cnt  = 0;
   bit arm       = 1'b0;
   bit force_low = 1'b0;
   logic [7:0] lx[$];
   logic [6:0] ly[$];
   logic [2:0] lc[$];

   shape_draw_sequencer dut (
      .clock(clock), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
      .shape_done(shape_done),
      .starting_address_loaded(starting_address_loaded),
      .start_x(start_x), .start_y(start_y), .start_colour(start_colour),
      .busy(busy), .shapes_drawn(shapes_drawn)
   );

   always #5 clock = ~clock;

   // Drawer model and strobe logger
   always @(posedge clock) begin
      #1;
      if (draw_cnt != 0) draw_cnt = draw_cnt - 1;
      if (arm) draw_cnt = draw_len;
      arm = starting_address_loaded;
      if (starting_address_loaded) begin
         lx.push_back(start_x);
         ly.push_back(start_y);
         lc.push_back(start_colour);
      end
      shape_done = (draw_cnt == 0) && !force_low;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_log();
      lx.delete();
      ly.delete();
      lc.delete();
   endtask

   task automatic wait_drain(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (lx.size() >= n && !busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) tick();
      n_assert++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
      n_assert++; if (starting_address_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", starting_address_loaded); end
      n_assert++; if ({start_x, start_y, start_colour} !== 18'd0) begin n_fail++; $display("FAIL reset_start: got %0d/%0d/%0d want 0/0/0", start_x, start_y, start_colour); end
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_assert++; if (shapes_drawn !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", shapes_drawn); end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      draw_len = 3600;
      clear_log();
      req_valid = 1'b1; req_x = 8'd10; req_y = 7'd20; req_colour = 3'd5;
      tick();
      req_valid = 1'b0;
      n_assert++; if (starting_address_loaded !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: strobe %b want 0", starting_address_loaded); end
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_n: got %b want 0", busy); end
      tick();
      n_assert++; if (starting_address_loaded !== 1'b1) begin n_fail++; $display("FAIL single_strobe: got %b want 1", starting_address_loaded); end
      n_assert++; if ({start_x, start_y, start_colour} !== {8'd10, 7'd20, 3'd5}) begin n_fail++; $display("FAIL single_start: got %0d/%0d/%0d want 10/20/5", start_x, start_y, start_colour); end
      n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
      tick();
      n_assert++; if (starting_address_loaded !== 1'b0) begin n_fail++; $display("FAIL single_strobe_len: got %b want 0", starting_address_loaded); end
      repeat (3600) tick();
      n_assert++; if (shapes_drawn !== 16'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_pre_done: count %0d busy %b want 0 1", shapes_drawn, busy); end
      tick();
      n_assert++; if (shapes_drawn !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: count %0d busy %b want 1 0", shapes_drawn, busy); end
      repeat (10) tick();
      n_assert++; if (lx.size() != 1) begin n_fail++; $display("FAIL single_one_strobe: got %0d strobes want 1", lx.size()); end
      n_assert++; if ({start_x, start_y, start_colour} !== {8'd10, 7'd20, 3'd5}) begin n_fail++; $display("FAIL single_hold: got %0d/%0d/%0d want 10/20/5", start_x, start_y, start_colour); end
      draw_len = 20;
   endtask

   task automatic test_fifo_full();
      logic [7:0] vx [5] = '{8'd1, 8'd50, 8'd100, 8'd200, 8'd255};
      logic [6:0] vy [5] = '{7'd0, 7'd33, 7'd64, 7'd100, 7'd127};
      logic [2:0] vc [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
      bit ok;
      #3 force_low = 1'b1;
      tick();
      clear_log();
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_x = vx[i]; req_y = vy[i]; req_colour = vc[i];
         n_assert++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_%0d: got %b want 1", i, req_ready); end
         tick();
      end
      req_x = vx[4]; req_y = vy[4]; req_colour = vc[4];
      n_assert++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %b want 0", req_ready); end
      repeat (5) tick();
      n_assert++; if (req_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_hold: ready %b busy %b want 0 0", req_ready, busy); end
      #3 force_low = 1'b0;
      tick();
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (req_ready) begin ok = 1'b1; break; end
         tick();
      end
      n_assert++; if (!ok) begin n_fail++; $display("FAIL full_reopen: ready %b want 1 within 20 cycles", req_ready); end
      tick();
      req_valid = 1'b0;
      wait_drain(5, 1000, ok);
      n_assert++; if (!ok || lx.size() != 5) begin n_fail++; $display("FAIL full_drain: got %0d strobes want 5", lx.size()); end
      for (int i = 0; i < 5 && i < lx.size(); i++) begin
         n_assert++;
         if ({lx[i], ly[i], lc[i]} !== {vx[i], vy[i], vc[i]}) begin
            n_fail++; $display("FAIL full_order_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, lx[i], ly[i], lc[i], vx[i], vy[i], vc[i]);
         end
      end
      n_assert++; if (shapes_drawn !== 16'd6) begin n_fail++; $display("FAIL full_count: got %0d want 6", shapes_drawn); end
   endtask

   task automatic test_push_pop();
      logic [7:0] vx [5] = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55};
      logic [6:0] vy [5] = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5};
      logic [2:0] vc [5] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
      bit ok;
      #3 force_low = 1'b1;
      tick();
      clear_log();
      for (int i = 0; i < 2; i++) begin
         req_valid = 1'b1; req_x = vx[i]; req_y = vy[i]; req_colour = vc[i];
         tick();
      end
      req_valid = 1'b0;
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pp_idle: busy %b want 0", busy); end
      #3 force_low = 1'b0;
      tick();
      // shape_done now rises; the next edge pops the head and pushes R
      req_valid = 1'b1; req_x = vx[2]; req_y = vy[2]; req_colour = vc[2];
      tick();
      n_assert++; if (starting_address_loaded !== 1'b1 || {start_x, start_y, start_colour} !== {vx[0], vy[0], vc[0]}) begin
         n_fail++; $display("FAIL pp_pop: strobe %b start %0d/%0d/%0d want 1 %0d/%0d/%0d", starting_address_loaded, start_x, start_y, start_colour, vx[0], vy[0], vc[0]);
      end
      for (int i = 3; i < 5; i++) begin
         req_x = vx[i]; req_y = vy[i]; req_colour = vc[i];
         tick();
      end
      req_valid = 1'b0;
      n_assert++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL pp_occupancy: ready %b want 0 after 2 more pushes", req_ready); end
      wait_drain(5, 1000, ok);
      n_assert++; if (!ok || lx.size() != 5) begin n_fail++; $display("FAIL pp_drain: got %0d strobes want 5", lx.size()); end
      for (int i = 0; i < 5 && i < lx.size(); i++) begin
         n_assert++;
         if ({lx[i], ly[i], lc[i]} !== {vx[i], vy[i], vc[i]}) begin
            n_fail++; $display("FAIL pp_order_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, lx[i], ly[i], lc[i], vx[i], vy[i], vc[i]);
         end
      end
      n_assert++; if (shapes_drawn !== 16'd11) begin n_fail++; $display("FAIL pp_count: got %0d want 11", shapes_drawn); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_log();
      req_valid = 1'b1; req_x = 8'd90; req_y = 7'd9; req_colour = 3'd1;
      tick();
      req_x = 8'd91; tick();
      req_x = 8'd92; tick();
      req_x = 8'd93; tick();
      req_valid = 1'b0;
      n_assert++; if (busy !== 1'b1 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_pre: busy %b ready %b want 1 1", busy, req_ready); end
      resetn = 1'b0;
      #2;
      n_assert++; if (req_ready !== 1'b1 || starting_address_loaded !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_ctl: ready %b strobe %b busy %b want 1 0 0", req_ready, starting_address_loaded, busy);
      end
      n_assert++; if ({start_x, start_y, start_colour} !== 18'd0 || shapes_drawn !== 16'd0) begin
         n_fail++; $display("FAIL mid_reset_data: start %0d/%0d/%0d count %0d want zeros", start_x, start_y, start_colour, shapes_drawn);
      end
      tick(); tick();
      resetn = 1'b1;
      clear_log();
      repeat (40) tick();
      n_assert++; if (lx.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_strobe: %0d strobes busy %b want 0 0", lx.size(), busy); end
      req_valid = 1'b1; req_x = 8'd77; req_y = 7'd5; req_colour = 3'd6;
      tick();
      req_valid = 1'b0;
      tick();
      n_assert++; if (starting_address_loaded !== 1'b1 || {start_x, start_y, start_colour} !== {8'd77, 7'd5, 3'd6}) begin
         n_fail++; $display("FAIL mid_fifo_empty: strobe %b start %0d/%0d/%0d want 1 77/5/6", starting_address_loaded, start_x, start_y, start_colour);
      end
      wait_drain(1, 500, ok);
      n_assert++; if (!ok || shapes_drawn !== 16'd1) begin n_fail++; $display("FAIL mid_count: got %0d want 1", shapes_drawn); end
   endtask

`ifdef ERASE_PASS_EN
   task automatic test_erase();
      bit ok;
      clear_log();
      req_valid = 1'b1; req_x = 8'd10; req_y = 7'd20; req_colour = 3'd5;
      tick();
      req_valid = 1'b0;
      wait_drain(1, 500, ok);
      req_valid = 1'b1; req_x = 8'd30;
      tick();
      req_valid = 1'b0;
      wait_drain(3, 1000, ok);
      n_assert++; if (!ok || lx.size() != 3) begin n_fail++; $display("FAIL erase_drain: got %0d strobes want 3", lx.size()); end
      n_assert++; if (lx.size() > 1 && {lx[1], ly[1], lc[1]} !== {8'd10, 7'd20, 3'd0}) begin n_fail++; $display("FAIL erase_shape: got %0d/%0d/%0d want 10/20/0", lx[1], ly[1], lc[1]); end
      n_assert++; if (lx.size() > 2 && {lx[2], ly[2], lc[2]} !== {8'd30, 7'd20, 3'd5}) begin n_fail++; $display("FAIL erase_new: got %0d/%0d/%0d want 30/20/5", lx[2], ly[2], lc[2]); end
      n_assert++; if (shapes_drawn !== 16'd3) begin n_fail++; $display("FAIL erase_count: got %0d want 3", shapes_drawn); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef ERASE_PASS_EN
      test_erase();
`else
      test_single();
      test_fifo_full();
      test_push_pop();
      test_reset_mid();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
